// File: rtl/jt9346_master.sv
// Serial command master for a 93C46-style EEPROM: turns one-cycle requests into
// start/opcode/address/data frames on sclk/sdi/scs and polls sdo for write completion.
module jt9346_master #(
  parameter int AW  = 6,
  parameter int DW  = 16,
  parameter int DIV = 4,
  parameter int TMO = 65535
) (
  input  logic          rst,
  input  logic          clk,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] rdata,
  output logic          err,
  output logic          sclk,
  output logic          sdi,
  output logic          scs,
  input  logic          sdo
);

  localparam int HW = 3 + AW;
  localparam int FW = HW + DW;
  localparam int PW = $clog2(FW + 1);
  localparam int CW = $clog2(DIV + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CSLOW, WAIT, ENDCS, DONE} state_t;

  state_t        state_reg;
  logic [FW-1:0] tx_reg;
  logic [DW-1:0] rx_reg;
  logic [PW-1:0] pulse_reg, n_reg, pulse_inc;
  logic [CW-1:0] cnt_reg;
  logic [TW-1:0] tmo_reg;
  logic          read_cmd_reg, wait_cmd_reg;

  logic [1:0]    opc;
  logic [AW-1:0] afield;
  logic          has_data, is_read, is_wait;
  logic [FW-1:0] frame;

  // Frame decode; the 00-opcode group carries its sub-command in the top two address bits.
  always_comb begin
    opc      = 2'b00;
    afield   = addr;
    has_data = 1'b0;
    is_read  = 1'b0;
    is_wait  = 1'b0;
    case (op)
      3'd0: begin opc = 2'b10; is_read = 1'b1; end
      3'd1: begin opc = 2'b01; has_data = 1'b1; is_wait = 1'b1; end
      3'd2: begin opc = 2'b11; is_wait = 1'b1; end
      3'd3: afield = {2'b11, {(AW-2){1'b0}}};
      3'd5: begin afield = {2'b01, {(AW-2){1'b0}}}; has_data = 1'b1; is_wait = 1'b1; end
      3'd6: begin afield = {2'b10, {(AW-2){1'b0}}}; is_wait = 1'b1; end
      default: afield = {2'b00, {(AW-2){1'b0}}};
    endcase
    frame = {1'b1, opc, afield, has_data ? wdata : {DW{1'b0}}};
  end

  assign pulse_inc = pulse_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      rdata        <= '0;
      err          <= 1'b0;
      sclk         <= 1'b0;
      sdi          <= 1'b0;
      scs          <= 1'b0;
      tx_reg       <= '0;
      rx_reg       <= '0;
      pulse_reg    <= '0;
      n_reg        <= '0;
      cnt_reg      <= '0;
      tmo_reg      <= '0;
      read_cmd_reg <= 1'b0;
      wait_cmd_reg <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: if (start) begin
          state_reg    <= SHIFT;
          busy         <= 1'b1;
          err          <= 1'b0;
          scs          <= 1'b1;
          sclk         <= 1'b0;
          sdi          <= 1'b1;
          tx_reg       <= {frame[FW-2:0], 1'b0};
          n_reg        <= (has_data || is_read) ? PW'(FW) : PW'(HW);
          read_cmd_reg <= is_read;
          wait_cmd_reg <= is_wait;
          cnt_reg      <= '0;
          pulse_reg    <= '0;
        end
        SHIFT: if (cnt_reg == CW'(DIV - 1)) begin
          cnt_reg <= '0;
          if (sclk) begin
            // End of a high phase: sample read data, then present the next bit on the falling edge.
            sclk      <= 1'b0;
            pulse_reg <= pulse_inc;
            if (read_cmd_reg && pulse_reg >= PW'(HW))
              rx_reg <= {rx_reg[DW-2:0], sdo};
            if (pulse_inc == n_reg) begin
              sdi <= 1'b0;
            end else begin
              sdi    <= tx_reg[FW-1];
              tx_reg <= {tx_reg[FW-2:0], 1'b0};
            end
          end else if (pulse_reg == n_reg) begin
            scs       <= 1'b0;
            state_reg <= CSLOW;
          end else begin
            sclk <= 1'b1;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        // Non-wait commands hold chip select low one extra cycle before done.
        CSLOW: if (cnt_reg == (wait_cmd_reg ? CW'(DIV - 1) : CW'(DIV))) begin
          cnt_reg <= '0;
          if (wait_cmd_reg) begin
            state_reg <= WAIT;
            scs       <= 1'b1;
            tmo_reg   <= '0;
          end else begin
            state_reg <= DONE;
            done      <= 1'b1;
            busy      <= 1'b0;
            if (read_cmd_reg) rdata <= rx_reg;
          end
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        WAIT: if (sdo || tmo_reg == TW'(TMO)) begin
          err       <= ~sdo;
          scs       <= 1'b0;
          cnt_reg   <= '0;
          state_reg <= ENDCS;
        end else if (tmo_reg != {TW{1'b1}}) begin
          tmo_reg <= tmo_reg + 1'b1;
        end
        ENDCS: if (cnt_reg == CW'(DIV - 1)) begin
          cnt_reg   <= '0;
          state_reg <= DONE;
          done      <= 1'b1;
          busy      <= 1'b0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
        DONE: state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
